// File: rtl/stream2ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stream2ram
// Purpose  : Writes a valid/ready word stream into a ping-pong RAM and
//            announces each filled bank to the drain stage.
// Revision : 1.0 - initial release
// ============================================================================
module stream2ram #(
  parameter int DW = 8,
  parameter int BW = 9,
  parameter int AW = BW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          flush,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          bank_ready,
  output logic          bank_id,
  output logic [BW:0]   bank_len,
  input  logic          rd_done,
  input  logic          rd_bank,
  output logic          ovf
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PUBLISH = 2'd1,
    WAIT    = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          wr_bank, wr_bank_nx;
  logic [BW-1:0] offset, offset_nx;
  logic [BW:0]   len_r, len_nx;
  logic [1:0]    busy, busy_nx;
  logic          accept;
  logic          last_word;

  // In FILL the bank being written is never busy, so this only gates on state.
  assign din_ready = (state == FILL) && !busy[wr_bank];
  assign accept    = din_valid && din_ready;
  assign last_word = (offset == {BW{1'b1}});

  always_comb begin
    state_nx   = state;
    wr_bank_nx = wr_bank;
    offset_nx  = offset;
    len_nx     = len_r;
    busy_nx    = busy;
    if (rd_done) busy_nx[rd_bank] = 1'b0;
    case (state)
      FILL: begin
        if (accept) offset_nx = offset + BW'(1);
        if ((accept && (last_word || flush)) || (flush && !accept && (offset != '0))) begin
          state_nx         = PUBLISH;
          len_nx           = {1'b0, offset} + (BW+1)'(accept);
          // Assigned after the rd_done clear so a simultaneous set wins.
          busy_nx[wr_bank] = 1'b1;
        end
      end
      PUBLISH: begin
        wr_bank_nx = ~wr_bank;
        offset_nx  = '0;
        state_nx   = busy[~wr_bank] ? WAIT : FILL;
      end
      WAIT: begin
        if (!busy[wr_bank]) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_bank    <= 1'b0;
      offset     <= '0;
      len_r      <= '0;
      busy       <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      bank_ready <= 1'b0;
      bank_id    <= 1'b0;
      bank_len   <= '0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_bank    <= wr_bank_nx;
      offset     <= offset_nx;
      len_r      <= len_nx;
      busy       <= busy_nx;
      ram_we     <= accept;
      if (accept) begin
        ram_addr <= {wr_bank, offset};
        ram_din  <= din;
      end
      bank_ready <= (state == PUBLISH);
      if (state == PUBLISH) begin
        bank_id  <= wr_bank;
        bank_len <= len_r;
      end
      if (din_valid && !din_ready) ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream2ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stream2ram
// Purpose  : Scenario-driven bench for stream2ram with a bank-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream2ram;
  localparam int DW = 8;
  localparam int BW = 9;
  localparam int AW = BW + 1;
  localparam int DEPTH = 1 << BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          flush = 1'b0;
  logic          rd_done = 1'b0;
  logic          rd_bank = 1'b0;
  logic          din_ready, ram_we, bank_ready, bank_id, ovf;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [BW:0]   bank_len;

  always #5 clk = ~clk;

  stream2ram #(.DW(DW), .BW(BW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .bank_ready(bank_ready), .bank_id(bank_id), .bank_len(bank_len),
    .rd_done(rd_done), .rd_bank(rd_bank), .ovf(ovf)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int len;
    int cyc;
  } ann_t;

  ann_t          obs_q[$];
  ann_t          exp_q[$];
  logic [DW-1:0] dut_ram [0:2*DEPTH-1];
  logic [DW-1:0] exp_ram [0:2*DEPTH-1];
  int            wr_count = 0;
  int            last_addr = -1;

  // Observed side: the RAM as the DUT writes it and every bank announcement.
  always @(negedge clk) begin
    ann_t a;
    if (ram_we) begin
      dut_ram[ram_addr] = ram_din;
      wr_count++;
      last_addr = int'(ram_addr);
    end
    if (bank_ready) begin
      a.id = int'(bank_id);
      a.len = int'(bank_len);
      a.cyc = cyc;
      obs_q.push_back(a);
    end
  end

  // Bank-level reference: a bank being filled, a publish in flight, or a
  // writer blocked because the next bank has not been released yet.
  int m_bank, m_cnt, m_plen, m_acc;
  bit m_busy[2];
  bit m_pub, m_closed, m_ovf;

  function automatic bit model_ready();
    return !m_pub && !m_closed;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [DW-1:0] d,
                            input bit fl, input bit rdd, input bit rdb);
    bit nb[2];
    bit acc;
    ann_t a;
    if (r) begin
      m_bank = 0; m_cnt = 0; m_plen = 0;
      m_busy[0] = 0; m_busy[1] = 0;
      m_pub = 0; m_closed = 0; m_ovf = 0;
      return;
    end
    acc = v && model_ready();
    if (v && !acc) m_ovf = 1;
    nb = m_busy;
    if (rdd) nb[rdb] = 0;
    if (m_pub) begin
      a.id = m_bank; a.len = m_plen; a.cyc = cyc + 1;
      exp_q.push_back(a);
      m_bank = 1 - m_bank;
      m_cnt = 0;
      m_pub = 0;
      m_closed = m_busy[m_bank];
    end else if (m_closed) begin
      if (!m_busy[m_bank]) m_closed = 0;
    end else begin
      if (acc) begin
        exp_ram[m_bank*DEPTH + m_cnt] = d;
        m_cnt++;
        m_acc++;
      end
      if (m_cnt == DEPTH || (fl && m_cnt > 0)) begin
        m_pub = 1;
        m_plen = m_cnt;
        nb[m_bank] = 1;
      end
    end
    m_busy = nb;
  endtask

  // One clock: drive inputs, advance the model, return observed/predicted ready.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit fl,
                      input bit rdd, input bit rdb, output bit obs_rdy, output bit exp_rdy);
    rst = r; din_valid = v; din = d; flush = fl; rd_done = rdd; rd_bank = rdb;
    obs_rdy = din_ready;
    exp_rdy = model_ready();
    model_edge(r, v, d, fl, rdd, rdb);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit o, e;
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, 0, o, e);
  endtask

  task automatic do_reset();
    bit o, e;
    step(1, 0, '0, 0, 0, 0, o, e);
    step(1, 0, '0, 0, 0, 0, o, e);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit o, e;
    do_reset();
    vectors++;
    if ({ram_we, bank_ready, bank_id, bank_len, ovf, ram_addr, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b br=%b id=%b len=%0d ovf=%b addr=%0d din=%0d, want all 0",
               ram_we, bank_ready, bank_id, bank_len, ovf, ram_addr, ram_din);
    end
    step(0, 0, '0, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got din_ready=%b, want 1", o);
    end
  endtask

  task automatic test_full_bank();
    bit o, e;
    int t_last, low, bad, wc0;
    do_reset();
    wc0 = wr_count;
    t_last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) t_last = cyc;
      step(0, 1, DW'(i), 0, 0, 0, o, e);
      vectors++;
      if (o !== e || o !== 1'b1) begin
        miscompares++;
        $display("FAIL full_bank_ready word %0d: got %b, want %b", i, o, e);
      end
    end
    low = 0;
    for (int j = 0; j < 4; j++) begin
      step(0, 0, '0, 0, 0, 0, o, e);
      if (!o) low++;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_bank_gap_ready cycle %0d: got %b, want %b", j, o, e);
      end
    end
    vectors++;
    if (low != 1) begin
      miscompares++;
      $display("FAIL full_bank_ready_low: got %0d low cycles, want 1", low);
    end
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL full_bank_ann_count: got %0d, want 1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0].id != 0 || obs_q[0].len != DEPTH || obs_q[0].cyc != t_last + 2) begin
        miscompares++;
        $display("FAIL full_bank_ann: got id=%0d len=%0d cyc=%0d, want id=0 len=%0d cyc=%0d",
                 obs_q[0].id, obs_q[0].len, obs_q[0].cyc, DEPTH, t_last + 2);
      end
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (dut_ram[a] !== DW'(a)) bad++;
    vectors++;
    if (bad != 0 || wr_count - wc0 != DEPTH) begin
      miscompares++;
      $display("FAIL full_bank_ram: got %0d bad words, %0d writes, want 0 bad, %0d writes",
               bad, wr_count - wc0, DEPTH);
    end
  endtask

  task automatic test_wait_ovf();
    bit o, e;
    int wc, bad;
    obs_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, DW'($urandom), 0, 0, 0, o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wait_fill_ready word %0d: got %b, want %b", i, o, e);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, '0, 0, 0, 0, o, e);
      vectors++;
      if (o !== e || o !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_blocked_ready cycle %0d: got %b, want 0", j, o);
      end
    end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0].id != 1 || obs_q[0].len != DEPTH) begin
      miscompares++;
      $display("FAIL wait_ann: got count=%0d, want one announcement id=1 len=%0d", obs_q.size(), DEPTH);
    end
    wc = wr_count;
    step(0, 1, 8'hA5, 0, 0, 0, o, e);
    idle(2);
    vectors++;
    if (ovf !== 1'b1 || wr_count != wc) begin
      miscompares++;
      $display("FAIL wait_ovf: got ovf=%b writes=%0d, want ovf=1 writes=0", ovf, wr_count - wc);
    end
    step(0, 0, '0, 0, 1, 0, o, e);
    step(0, 0, '0, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b0 || o !== e) begin
      miscompares++;
      $display("FAIL wait_release_early: got din_ready=%b one cycle after rd_done, want 0", o);
    end
    step(0, 1, 8'h3C, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b1 || o !== e) begin
      miscompares++;
      $display("FAIL wait_release: got din_ready=%b two cycles after rd_done, want 1", o);
    end
    vectors++;
    if (last_addr != 0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_resume: got addr=%0d ovf=%b, want addr=0 ovf=1", last_addr, ovf);
    end
    bad = 0;
    for (int a = DEPTH; a < 2*DEPTH; a++) if (dut_ram[a] !== exp_ram[a]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wait_bank1_ram: got %0d bad words, want 0", bad);
    end
  endtask

  task automatic test_flush();
    bit o, e;
    do_reset();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ovf_cleared: got ovf=%b, want 0", ovf);
    end
    for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom), 0, 0, 0, o, e);
    step(0, 0, '0, 1, 0, 0, o, e);
    idle(3);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0].id != 0 || obs_q[0].len != 5) begin
      miscompares++;
      $display("FAIL flush_ann: got count=%0d, want one announcement id=0 len=5", obs_q.size());
    end
    step(0, 1, DW'($urandom), 0, 0, 0, o, e);
    vectors++;
    if (last_addr != DEPTH) begin
      miscompares++;
      $display("FAIL flush_next_addr: got %0d, want %0d", last_addr, DEPTH);
    end
  endtask

  task automatic test_flush_accept();
    bit o, e;
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, DW'($urandom), 0, 0, 0, o, e);
    step(0, 1, DW'($urandom), 1, 0, 0, o, e);
    idle(3);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0].id != 0 || obs_q[0].len != 7) begin
      miscompares++;
      $display("FAIL flush_accept_ann: got count=%0d, want one announcement id=0 len=7", obs_q.size());
    end
    step(0, 0, '0, 1, 0, 0, o, e);
    idle(3);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL flush_empty: got %0d announcements, want 1", obs_q.size());
    end
  endtask

  task automatic test_busy_race();
    bit o, e;
    do_reset();
    step(0, 0, '0, 0, 1, 1, o, e);
    step(0, 1, 8'h11, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b1 || o !== e) begin
      miscompares++;
      $display("FAIL spurious_rd_done_ready: got %b, want 1", o);
    end
    idle(1);
    vectors++;
    if (last_addr != 0) begin
      miscompares++;
      $display("FAIL spurious_rd_done_addr: got %0d, want 0", last_addr);
    end
    step(0, 1, 8'h22, 0, 0, 0, o, e);
    step(0, 1, 8'h33, 1, 0, 0, o, e);
    idle(2);
    step(0, 0, '0, 0, 1, 0, o, e);
    step(0, 1, 8'h44, 0, 0, 0, o, e);
    step(0, 1, 8'h55, 0, 0, 0, o, e);
    step(0, 1, 8'h66, 1, 1, 1, o, e);
    idle(2);
    step(0, 1, 8'h77, 1, 0, 0, o, e);
    for (int j = 0; j < 5; j++) begin
      step(0, 0, '0, 0, 0, 0, o, e);
      vectors++;
      if (o !== 1'b0 || o !== e) begin
        miscompares++;
        $display("FAIL race_busy_held cycle %0d: got din_ready=%b, want 0", j, o);
      end
    end
    vectors++;
    if (obs_q.size() != 3 || obs_q[1].id != 1 || obs_q[1].len != 3) begin
      miscompares++;
      $display("FAIL race_ann: got count=%0d, want 3 with bank1 len 3 second", obs_q.size());
    end
    step(0, 0, '0, 0, 1, 1, o, e);
    idle(1);
    step(0, 0, '0, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b1 || o !== e) begin
      miscompares++;
      $display("FAIL race_release: got din_ready=%b, want 1", o);
    end
  endtask

  task automatic test_reset_publish();
    bit o, e;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, DW'($urandom), 0, 0, 0, o, e);
    step(0, 0, '0, 1, 0, 0, o, e);
    step(1, 0, '0, 0, 0, 0, o, e);
    step(0, 0, '0, 0, 0, 0, o, e);
    vectors++;
    if (o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_publish_ready: got %b, want 1", o);
    end
    idle(3);
    vectors++;
    if (obs_q.size() != 0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_publish_suppress: got %0d announcements ovf=%b, want 0 and 0", obs_q.size(), ovf);
    end
    step(0, 1, 8'h5A, 0, 0, 0, o, e);
    vectors++;
    if (last_addr != 0) begin
      miscompares++;
      $display("FAIL rst_publish_addr: got %0d, want 0", last_addr);
    end
  endtask

  task automatic test_random();
    bit o, e;
    int bad, n;
    do_reset();
    m_acc = 0;
    wr_count = 0;
    for (int i = 0; i < 3000; i++) begin
      step(0, ($urandom % 4) != 0, DW'($urandom), ($urandom % 40) == 0,
           ($urandom % 8) == 0, $urandom % 2, o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_ready cycle %0d: got %b, want %b", i, o, e);
      end
    end
    idle(3);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_ann_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (obs_q[k].id != exp_q[k].id || obs_q[k].len != exp_q[k].len || obs_q[k].cyc != exp_q[k].cyc) begin
        miscompares++;
        $display("FAIL random_ann %0d: got id=%0d len=%0d cyc=%0d, want id=%0d len=%0d cyc=%0d", k,
                 obs_q[k].id, obs_q[k].len, obs_q[k].cyc, exp_q[k].id, exp_q[k].len, exp_q[k].cyc);
      end
    end
    bad = 0;
    for (int a = 0; a < 2*DEPTH; a++) if (dut_ram[a] !== exp_ram[a]) bad++;
    vectors++;
    if (bad != 0 || wr_count != m_acc || ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL random_ram: got %0d bad words writes=%0d ovf=%b, want 0 writes=%0d ovf=%b",
               bad, wr_count, ovf, m_acc, m_ovf);
    end
  endtask

  initial begin
    for (int a = 0; a < 2*DEPTH; a++) begin
      dut_ram[a] = '0;
      exp_ram[a] = '0;
    end
    m_acc = 0;
    model_edge(1, 0, '0, 0, 0, 0);
    @(negedge clk);
    #1;
    test_reset();
    test_full_bank();
    test_wait_ovf();
    test_flush();
    test_flush_accept();
    test_busy_race();
    test_reset_publish();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
